// File: rtl/nl_lock_matrix_arb.sv
// Matrix arbiter with packet-level grant locking; priority moves only when a packet completes.
// Optional lock-timeout watchdog enabled by defining NL_LOCK_ARB_TIMEOUT_EN.

module nl_lock_matrix_lane #(
    parameter int SIZE = 5,
    parameter int IDX  = 0
) (
    input  logic [SIZE-1:0] request,
    input  logic [SIZE-1:0] beats_me,  // beats_me[j]: requester j has priority over IDX
    output logic            win
);
    localparam logic [SIZE-1:0] SELF = {{(SIZE-1){1'b0}}, 1'b1} << IDX;

    assign win = request[IDX] & ~|(request & beats_me & ~SELF);
endmodule

module nl_lock_matrix_arb #(
    parameter int SIZE       = 5,
    parameter int MULTISTAGE = 0,
    parameter int MAX_LOCK   = 32,
    parameter int OW         = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] request,
    input  logic [SIZE-1:0] tail,
    input  logic            success,
    output logic [SIZE-1:0] grant,
    output logic            locked,
    output logic [OW-1:0]   owner,
    output logic            timeout
);
    if (SIZE < 2) begin : g_bad_size
        $error("nl_lock_matrix_arb: SIZE must be >= 2");
    end
    if (MAX_LOCK < 2) begin : g_bad_max_lock
        $error("nl_lock_matrix_arb: MAX_LOCK must be >= 2");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                    state, state_nx;
    logic [SIZE-1:0][SIZE-1:0] prio;      // prio[i][j]: i beats j
    logic [SIZE-1:0][SIZE-1:0] beats_me;
    logic [SIZE-1:0]           win;
    logic [SIZE-1:0]           own_oh;
    logic [OW-1:0]             win_idx, owner_nx, upd_idx;
    logic                      commit, tail_hit, upd, to_nx;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            assign beats_me[i][j] = prio[j][i];
        end
        nl_lock_matrix_lane #(.SIZE(SIZE), .IDX(i)) u_lane (
            .request  (request),
            .beats_me (beats_me[i]),
            .win      (win[i])
        );
    end

    assign own_oh = {{(SIZE-1){1'b0}}, 1'b1} << owner;

    always_comb begin
        grant = '0;
        if (state == IDLE) grant = win;
        else if (request[owner]) grant = own_oh;
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < SIZE; i++)
            if (grant[i]) win_idx = OW'(i);
    end

    assign commit   = |grant & ((MULTISTAGE != 0) ? success : 1'b1);
    assign tail_hit = |(grant & tail);  // tails of non-granted requesters never matter

`ifdef NL_LOCK_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_LOCK);
    logic [CW-1:0] cnt;
    logic          cnt_max;
    assign cnt_max = (cnt == CW'(MAX_LOCK - 1));
`endif

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        upd      = 1'b0;
        upd_idx  = win_idx;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    if (tail_hit) begin
                        upd = 1'b1;
                    end else begin
                        state_nx = LOCKED;
                        owner_nx = win_idx;
                    end
                end
            end
            LOCKED: begin
                upd_idx = owner;
                if (commit && tail_hit) begin
                    upd      = 1'b1;
                    state_nx = IDLE;
`ifdef NL_LOCK_ARB_TIMEOUT_EN
                end else if (cnt_max) begin
                    upd      = 1'b1;
                    state_nx = IDLE;
                    to_nx    = 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    prio[i][j] <= (i > j);
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            // demote the winner below everyone; others keep their relative order
            if (upd) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (j != int'(upd_idx)) begin
                        prio[upd_idx][j] <= 1'b0;
                        prio[j][upd_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef NL_LOCK_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= to_nx;
            if (state == IDLE)  cnt <= '0;
            else if (!(commit && tail_hit)) cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_to;
    assign unused_to = to_nx;
    assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_nl_lock_matrix_arb.sv
// Directed bench for nl_lock_matrix_arb: SIZE=4 single-stage and multistage instances
// sharing stimulus; expected results queued at drive time and popped at observation.

module tb_nl_lock_matrix_arb;
    logic       clk, rst_n;
    logic [3:0] request, tail;
    logic       success;
    logic [3:0] g0, g1;
    logic       l0, l1, t0, t1;
    logic [1:0] o0, o1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic       locked;
        logic [1:0] owner;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];

    nl_lock_matrix_arb #(.SIZE(4), .MULTISTAGE(0), .MAX_LOCK(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .request(request), .tail(tail), .success(success),
        .grant(g0), .locked(l0), .owner(o0), .timeout(t0)
    );

    nl_lock_matrix_arb #(.SIZE(4), .MULTISTAGE(1), .MAX_LOCK(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .request(request), .tail(tail), .success(success),
        .grant(g1), .locked(l1), .owner(o1), .timeout(t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit bench did not finish");
        $fatal(1, "time limit");
    end

    // one clock cycle: drive, check combinational grant, then registered state after the edge
    task automatic cyc(input string tag, input bit sel, input bit rst,
                       input logic [3:0] req, input logic [3:0] tl, input logic sc,
                       input logic [3:0] eg, input logic el, input logic [1:0] eo,
                       input logic et);
        exp_t e;
        logic [3:0] og;
        logic       ol, ot;
        logic [1:0] oo;
        @(negedge clk);
        rst_n = ~rst; request = req; tail = tl; success = sc;
        exp_q.push_back('{tag, eg, el, eo, et});
        #1;
        e  = exp_q[0];
        og = sel ? g1 : g0;
        n_assert++;
        assert (og === e.grant) else begin
            n_fail++;
            $error("FAIL %s grant observed %b expected %b", e.tag, og, e.grant);
        end
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        ol = sel ? l1 : l0;
        oo = sel ? o1 : o0;
        ot = sel ? t1 : t0;
        n_assert++;
        assert (ol === e.locked) else begin
            n_fail++;
            $error("FAIL %s locked observed %b expected %b", e.tag, ol, e.locked);
        end
        n_assert++;
        assert (oo === e.owner) else begin
            n_fail++;
            $error("FAIL %s owner observed %0d expected %0d", e.tag, oo, e.owner);
        end
        n_assert++;
        assert (ot === e.timeout) else begin
            n_fail++;
            $error("FAIL %s timeout observed %b expected %b", e.tag, ot, e.timeout);
        end
    endtask

    initial begin
        rst_n = 1'b0; request = '0; tail = '0; success = 1'b0;

        // reset state and single-flit round robin
        cyc("rst0",     0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("rr_a",     0, 0, 4'b0101, 4'b0101, 0, 4'b0100, 0, 2'd0, 0);
        cyc("rr_b",     0, 0, 4'b0101, 4'b0101, 0, 4'b0001, 0, 2'd0, 0);
        cyc("rr_c",     0, 0, 4'b0101, 4'b0101, 0, 4'b0100, 0, 2'd0, 0);
        cyc("idle_z",   0, 0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);

        // multi-flit lock on 3; tail[0] of the loser is ignored
        cyc("rst1",     0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("lk_start", 0, 0, 4'b1001, 4'b0001, 0, 4'b1000, 1, 2'd3, 0);
        cyc("lk_hold1", 0, 0, 4'b1111, 4'b0111, 0, 4'b1000, 1, 2'd3, 0);
        cyc("lk_hold2", 0, 0, 4'b1111, 4'b0000, 0, 4'b1000, 1, 2'd3, 0);
        cyc("lk_hold3", 0, 0, 4'b1111, 4'b0000, 0, 4'b1000, 1, 2'd3, 0);
        cyc("lk_tail",  0, 0, 4'b1111, 4'b1000, 0, 4'b1000, 0, 2'd3, 0);
        cyc("lk_after", 0, 0, 4'b1001, 4'b1001, 0, 4'b0001, 0, 2'd3, 0);

        // multistage: no commit without success
        cyc("ms_rst",   1, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("ms_ns1",   1, 0, 4'b0010, 4'b0000, 0, 4'b0010, 0, 2'd0, 0);
        cyc("ms_ns2",   1, 0, 4'b0010, 4'b0000, 0, 4'b0010, 0, 2'd0, 0);
        cyc("ms_prio",  1, 0, 4'b0011, 4'b0011, 0, 4'b0010, 0, 2'd0, 0);
        cyc("ms_lock",  1, 0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 2'd1, 0);
        cyc("ms_tl_ns", 1, 0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        cyc("ms_tl_s",  1, 0, 4'b0010, 4'b0010, 1, 4'b0010, 0, 2'd1, 0);
        cyc("ms_after", 1, 0, 4'b0011, 4'b0011, 1, 4'b0001, 0, 2'd1, 0);

        // owner drops request while locked, then reset mid-packet
        cyc("dr_rst",   0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("dr_lock",  0, 0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2'd2, 0);
        cyc("dr_drop",  0, 0, 4'b1011, 4'b1011, 0, 4'b0000, 1, 2'd2, 0);
        cyc("dr_raise", 0, 0, 4'b1111, 4'b0000, 0, 4'b0100, 1, 2'd2, 0);
        cyc("mid_rst",  0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("post_rst", 0, 0, 4'b0111, 4'b0111, 0, 4'b0100, 0, 2'd0, 0);

`ifdef NL_LOCK_ARB_TIMEOUT_EN
        // watchdog: MAX_LOCK=4 releases after four locked cycles
        cyc("to_rst",   0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("to_lock",  0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        cyc("to_c0",    0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        cyc("to_c1",    0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        cyc("to_c2",    0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 1'b0);
        cyc("to_fire",  0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 0, 2'd0, 1);
        cyc("to_after", 0, 0, 4'b0011, 4'b0011, 0, 4'b0010, 0, 2'd0, 0);
`else
        // no watchdog: lock persists well past MAX_LOCK, timeout stays low
        cyc("nt_rst",   0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        cyc("nt_lock",  0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        for (int i = 0; i < 6; i++)
            cyc("nt_hold", 0, 0, 4'b0011, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        cyc("nt_tail",  0, 0, 4'b0011, 4'b0001, 0, 4'b0001, 0, 2'd0, 0);
        cyc("nt_after", 0, 0, 4'b0011, 4'b0011, 0, 4'b0010, 0, 2'd0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
